pwm_gen: RTL and testbench
==========================

PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter PRESC_DIV, default 100, meaning clk cycles per PWM step (range 1..65535).
REQ-002 SHALL have parameter STEPS, default 10, meaning PWM steps per period (range 2..15), matching the duty scale 0..10 of the animation stage.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  run request; level-sensitive.
REQ-006 SHALL have port duty_in  input  4  requested duty in steps, unsigned.
REQ-007 SHALL have port pwm_out  output  1  registered PWM waveform.
REQ-008 SHALL have port period_done  output  1  one-clk pulse at end of each PWM period.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port active_duty  output  4  duty value currently applied (shadow register).

Function
REQ-011 SHALL implement states IDLE, RUN, DRAIN in a single registered state variable.
REQ-012 SHALL keep a prescaler counter 0..PRESC_DIV-1 (width $clog2(PRESC_DIV), minimum 1); tick = prescaler at PRESC_DIV-1 while not IDLE; prescaler wraps to 0 on tick.
REQ-013 SHALL keep a step counter 0..STEPS-1 advancing by 1 on tick and wrapping STEPS-1 -> 0.
REQ-014 SHALL, in IDLE, hold prescaler, step, pwm_out, period_done at 0 and active_duty unchanged.
REQ-015 SHALL, in IDLE with en=1, go to RUN next clk, clear prescaler and step, and load active_duty = min(duty_in, STEPS).
REQ-016 SHALL load active_duty = min(duty_in, STEPS) only on the tick that wraps step to 0 (period boundary); duty_in changes mid-period SHALL NOT affect the current period.
REQ-017 SHALL register pwm_out each clk as (state != IDLE) AND (step < active_duty), using current-cycle register values (one clk latency).
REQ-018 SHALL give duty 0 a constant-low period and duty >= STEPS a constant-high period, with no glitch at the period boundary.
REQ-019 SHALL assert period_done for exactly one clk, registered, following each tick that wraps step from STEPS-1 to 0, in RUN or DRAIN.
REQ-020 SHALL, in RUN with en=0, go to DRAIN without disturbing counters or pwm_out.
REQ-021 SHALL, in DRAIN, finish the current period; on the wrap tick go to IDLE (clearing counters) if en=0, or to RUN if en=1.
REQ-022 SHALL, in DRAIN with en=1 before the wrap, return to RUN next clk with counters continuing.
REQ-023 SHALL drive busy combinationally from state (high in RUN and DRAIN).

Reset
REQ-024 SHALL, on rst=1, immediately set state IDLE, prescaler 0, step 0, active_duty 0, pwm_out 0, period_done 0, independent of clk.
REQ-025 SHALL, on rst mid-period, abandon the period without a period_done pulse; after release, operation resumes only via REQ-015.

Verification (PRESC_DIV=4, STEPS=10, period 40 clk)
REQ-026 SHALL cover: en=1, duty_in=3 held -> pwm_out high 12 clk then low 28 clk per period, period_done every 40 clk, active_duty=3.
REQ-027 SHALL cover: duty_in=0 -> pwm_out constantly 0; duty_in=15 -> active_duty=10, pwm_out constantly 1 across consecutive periods.
REQ-028 SHALL cover: duty_in 2 -> 7 at clk 10 of a period -> that period high 8 clk, next period high 28 clk.
REQ-029 SHALL cover: en dropped at clk 15 of a period -> busy stays 1, period completes, one period_done, then busy=0, pwm_out=0.
REQ-030 SHALL cover: sweep duty_in 0..10..0 once per period (animation-stage pattern) -> high time 4*duty clk each period, no missing or extra period_done.
REQ-031 SHALL cover: rst asserted mid-high-phase between clk edges -> pwm_out, busy, active_duty 0 immediately; no period_done.

Source files
------------

// File: rtl/pwm_gen.sv
// PWM generator: prescaled step counter with a per-period shadowed duty value
// and a drain state that lets the current period finish before going idle.
module pwm_gen #(
  parameter int PRESC_DIV = 100,
  parameter int STEPS     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] duty_in,
  output logic       pwm_out,
  output logic       period_done,
  output logic       busy,
  output logic [3:0] active_duty
);

  localparam int             PW         = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [3:0]     STEP_LAST  = 4'(STEPS - 1);
  localparam logic [3:0]     DUTY_MAX   = 4'(STEPS);

  // Requests beyond the step count mean "always high".
  function automatic logic [3:0] sat_duty(input logic [3:0] d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic [3:0]    step;
  logic          tick;
  logic          wrap;

  assign tick = (state != IDLE) && (presc == PRESC_LAST);
  assign wrap = tick && (step == STEP_LAST);
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (wrap)    state_nxt = en ? RUN : IDLE;
        else if (en) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Counters, duty shadow and registered outputs; the wrap tick is the only
  // point where a new duty takes effect, so a period is never split.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc       <= '0;
      step        <= '0;
      active_duty <= '0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else if (state == IDLE) begin
      presc       <= '0;
      step        <= '0;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
      if (en) active_duty <= sat_duty(duty_in);
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) step <= wrap ? 4'd0 : step + 4'd1;
      if (wrap) active_duty <= sat_duty(duty_in);
      period_done <= wrap;
      pwm_out     <= (step < active_duty);
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen with PRESC_DIV=4, STEPS=10 (40-clk period).
module tb_pwm_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] duty_in;
  logic       pwm_out;
  logic       period_done;
  logic       busy;
  logic [3:0] active_duty;

  int checks   = 0;
  int failures = 0;

  pwm_gen #(.PRESC_DIV(4), .STEPS(10)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .duty_in(duty_in),
    .pwm_out(pwm_out),
    .period_done(period_done),
    .busy(busy),
    .active_duty(active_duty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next sample on which period_done is seen, bounded.
  task automatic wait_pd(input string tag);
    bit found = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (period_done) begin
        found = 1;
        break;
      end
    end
    chk(tag, found, 1);
  endtask

  // Observe 40 samples; optionally change duty_in or drop en after a given sample.
  task automatic measure(input int chg_at, input logic [3:0] chg_val, input int drop_at,
                         output int hi, output int pd, output int bz);
    hi = 0; pd = 0; bz = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1)     hi++;
      if (period_done === 1'b1) pd++;
      if (busy === 1'b1)        bz++;
      if (i == chg_at)  duty_in = chg_val;
      if (i == drop_at) en = 1'b0;
    end
  endtask

  initial begin
    int hi, pd, bz, d, nd;
    rst = 1'b1; en = 1'b0; duty_in = 4'd0;
    #1;
    chk("rst_pwm", pwm_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_duty", active_duty, 0);
    chk("rst_pd", period_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Steady duty 3
    duty_in = 4'd3; en = 1'b1;
    @(negedge clk);
    chk("d3_busy", busy, 1);
    chk("d3_duty", active_duty, 3);
    wait_pd("d3_wait");
    for (int p = 0; p < 2; p++) begin
      measure(0, 4'd0, 0, hi, pd, bz);
      chk("d3_hi", hi, 12);
      chk("d3_pd", pd, 1);
    end

    // Duty 0 then saturated duty 15
    duty_in = 4'd0;
    wait_pd("d0_wait");
    chk("d0_duty", active_duty, 0);
    measure(0, 4'd0, 0, hi, pd, bz);
    chk("d0_hi", hi, 0);
    chk("d0_pd", pd, 1);
    duty_in = 4'd15;
    wait_pd("d15_wait");
    chk("d15_duty", active_duty, 10);
    for (int p = 0; p < 2; p++) begin
      measure(0, 4'd0, 0, hi, pd, bz);
      chk("d15_hi", hi, 40);
      chk("d15_pd", pd, 1);
    end

    // Mid-period duty change is deferred to the next period
    duty_in = 4'd2;
    wait_pd("chg_wait");
    measure(10, 4'd7, 0, hi, pd, bz);
    chk("chg_hi_cur", hi, 8);
    chk("chg_pd_cur", pd, 1);
    measure(0, 4'd0, 0, hi, pd, bz);
    chk("chg_hi_next", hi, 28);
    chk("chg_duty", active_duty, 7);

    // Drop en mid-period: period drains, then idle
    measure(0, 4'd0, 15, hi, pd, bz);
    chk("drain_hi", hi, 28);
    chk("drain_pd", pd, 1);
    chk("drain_busy", bz, 39);
    measure(0, 4'd0, 0, hi, pd, bz);
    chk("idle_hi", hi, 0);
    chk("idle_pd", pd, 0);
    chk("idle_busy", bz, 0);
    chk("idle_duty", active_duty, 7);

    // Sweep 0..10..0, one value per period
    duty_in = 4'd0; en = 1'b1;
    @(negedge clk);
    chk("sw_busy", busy, 1);
    chk("sw_duty0", active_duty, 0);
    for (int k = 0; k <= 20; k++) begin
      d  = (k <= 10) ? k : 20 - k;
      nd = (k + 1 <= 10) ? k + 1 : ((k + 1 <= 20) ? 19 - k : 0);
      measure(20, 4'(nd), 0, hi, pd, bz);
      chk($sformatf("sw_hi_%0d", k), hi, 4 * d);
      chk($sformatf("sw_pd_%0d", k), pd, 1);
    end

    // Asynchronous reset in the middle of a high phase
    duty_in = 4'd5;
    wait_pd("ar_wait");
    repeat (6) @(negedge clk);
    chk("ar_pre_pwm", pwm_out, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_pwm", pwm_out, 0);
    chk("ar_busy", busy, 0);
    chk("ar_duty", active_duty, 0);
    chk("ar_pd", period_done, 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    measure(0, 4'd0, 0, hi, pd, bz);
    chk("ar_post_pd", pd, 0);
    chk("ar_post_busy", bz, 0);
    chk("ar_post_hi", hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
